// File: rtl/pattern_serializer_pkg.sv
// Shared types and the reset-time thermometer pattern for the serializer.
package pattern_serializer_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int unsigned THERM_MAX_W = 64;

  // Entry i holds (2^(i+1))-1, clipped to width bits.
  function automatic logic [THERM_MAX_W-1:0] therm(input int unsigned i, input int unsigned width);
    logic [THERM_MAX_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < THERM_MAX_W; b++) begin
      if ((b <= i) && (b < width)) r[b] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_ram.sv
// DEPTH x WIDTH pattern register file: one synchronous write port,
// one asynchronous read port, thermometer contents on reset.
module pattern_ram
  import pattern_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(therm(i, WIDTH));
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read sees pre-edge contents, so a same-cycle write never leaks into a snapshot.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pattern_serializer.sv
// Streams a selected stored pattern one bit per clock, LSB- or MSB-first,
// one-shot or continuously looping, with abort.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned BW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [AW-1:0]    sel,
  input  logic             loop,
  input  logic             msb_first,
  input  logic             stop,
  output logic             o,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [BW-1:0]    bit_idx
);

  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    cur_sel;
  logic             cur_msb;
  logic             cont;
  logic [AW-1:0]    rd_addr_c;
  logic [BW-1:0]    nxt_idx_c;

  function automatic logic pick(input logic [WIDTH-1:0] v, input logic [BW-1:0] i, input logic m);
    return m ? v[LAST - i] : v[i];
  endfunction

  // IDLE reads the requested entry; SHIFT reads the latched one for loop reloads.
  assign rd_addr_c = (state == IDLE) ? sel : cur_sel;
  assign nxt_idx_c = bit_idx + BW'(1);

  pattern_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  // bit_idx always names the bit currently on o; cont holds the loop decision
  // taken when the last bit was launched, so done and the frame-end action agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      snap    <= '0;
      cur_sel <= '0;
      cur_msb <= 1'b0;
      cont    <= 1'b0;
      o       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap    <= rd_data;
            cur_sel <= sel;
            cur_msb <= msb_first;
            cont    <= loop;
            bit_idx <= '0;
            o       <= pick(rd_data, '0, msb_first);
            valid   <= 1'b1;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (stop) begin
            state   <= IDLE;
            o       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
          end else if (bit_idx == LAST) begin
            done <= 1'b0;
            if (cont) begin
              snap    <= rd_data;
              bit_idx <= '0;
              o       <= pick(rd_data, '0, cur_msb);
            end else begin
              state   <= IDLE;
              o       <= 1'b0;
              valid   <= 1'b0;
              busy    <= 1'b0;
              bit_idx <= '0;
            end
          end else begin
            bit_idx <= nxt_idx_c;
            o       <= pick(snap, nxt_idx_c, cur_msb);
            done    <= (nxt_idx_c == LAST) && !loop;
            cont    <= loop;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench: table of one-shot frames plus hand sequences for loop,
// stop, ignored start, same-cycle write/start, reset mid-frame and WIDTH=4.
module tb_pattern_serializer;

  logic clk;
  logic reset;

  logic       wr_en1, start1, loop1, msb1, stop1;
  logic [2:0] wr_addr1, sel1;
  logic [7:0] wr_data1;
  logic       o1, valid1, busy1, done1;
  logic [2:0] bit_idx1;

  logic       wr_en2, start2, loop2, msb2, stop2;
  logic [3:0] wr_addr2, sel2;
  logic [3:0] wr_data2;
  logic       o2, valid2, busy2, done2;
  logic [1:0] bit_idx2;

  int total = 0;
  int bad   = 0;

  pattern_serializer #(.WIDTH(8), .DEPTH(8)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .sel(sel1), .loop(loop1), .msb_first(msb1), .stop(stop1),
    .o(o1), .valid(valid1), .busy(busy1), .done(done1), .bit_idx(bit_idx1)
  );

  pattern_serializer #(.WIDTH(4), .DEPTH(16)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .start(start2), .sel(sel2), .loop(loop2), .msb_first(msb2), .stop(stop2),
    .o(o2), .valid(valid2), .busy(busy2), .done(done2), .bit_idx(bit_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       msb;
    logic [7:0] exp;   // exp[i] is the i-th bit sent
    string      name;
  } frame_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input int which, input string name, input int i,
                           input logic eo, input logic edone);
    logic       ao, av, ad;
    logic [3:0] ai;
    if (which == 1) begin
      ao = o1; av = valid1; ad = done1; ai = {1'b0, bit_idx1};
    end else begin
      ao = o2; av = valid2; ad = done2; ai = {2'b00, bit_idx2};
    end
    chk($sformatf("%s[%0d] o", name, i), 32'(ao), 32'(eo));
    chk($sformatf("%s[%0d] valid", name, i), 32'(av), 32'(1'b1));
    chk($sformatf("%s[%0d] bit_idx", name, i), 32'(ai), 32'(i));
    chk($sformatf("%s[%0d] done", name, i), 32'(ad), 32'(edone));
  endtask

  task automatic run_frame(input int which, input logic [3:0] s, input logic m,
                           input logic [7:0] exp, input int w, input string name);
    if (which == 1) begin
      start1 = 1'b1; sel1 = s[2:0]; msb1 = m; loop1 = 1'b0;
    end else begin
      start2 = 1'b1; sel2 = s; msb2 = m; loop2 = 1'b0;
    end
    step();
    start1 = 1'b0; start2 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
    for (int i = 0; i < w; i++) begin
      check_bit(which, name, i, exp[i], i == w - 1);
      step();
    end
    chk({name, " busy_after"}, 32'((which == 1) ? busy1 : busy2), 32'(1'b0));
    chk({name, " valid_after"}, 32'((which == 1) ? valid1 : valid2), 32'(1'b0));
  endtask

  initial begin
    frame_vec_t vecs[5];
    logic [7:0] pat;

    vecs[0] = '{3'd2, 1'b0, 8'h07, "s2_lsb"};
    vecs[1] = '{3'd3, 1'b1, 8'hF0, "s3_msb"};
    vecs[2] = '{3'd7, 1'b0, 8'hFF, "s7_lsb"};
    vecs[3] = '{3'd0, 1'b1, 8'h80, "s0_msb"};
    vecs[4] = '{3'd6, 1'b1, 8'hFE, "s6_msb"};

    reset = 1'b1;
    wr_en1 = 0; start1 = 0; loop1 = 0; msb1 = 0; stop1 = 0; wr_addr1 = 0; sel1 = 0; wr_data1 = 0;
    wr_en2 = 0; start2 = 0; loop2 = 0; msb2 = 0; stop2 = 0; wr_addr2 = 0; sel2 = 0; wr_data2 = 0;
    repeat (3) step();

    chk("rst o", 32'(o1), 0);
    chk("rst valid", 32'(valid1), 0);
    chk("rst busy", 32'(busy1), 0);
    chk("rst done", 32'(done1), 0);
    chk("rst bit_idx", 32'(bit_idx1), 0);
    reset = 1'b0;
    step();

    // One-shot frames from the reset-time thermometer table
    for (int v = 0; v < 5; v++) begin
      run_frame(1, {1'b0, vecs[v].sel}, vecs[v].msb, vecs[v].exp, 8, vecs[v].name);
    end

    // Looping with a mid-frame write, then loop dropped
    wr_en1 = 1'b1; wr_addr1 = 3'd5; wr_data1 = 8'hA5;
    step();
    wr_en1 = 1'b0;
    start1 = 1'b1; sel1 = 3'd5; msb1 = 1'b0; loop1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int f = 0; f < 3; f++) begin
      pat = (f < 2) ? 8'hA5 : 8'h0F;
      for (int i = 0; i < 8; i++) begin
        check_bit(1, $sformatf("loop%0d", f), i, pat[i], (f == 2) && (i == 7));
        if (f == 1 && i == 2) begin
          wr_en1 = 1'b1; wr_addr1 = 3'd5; wr_data1 = 8'h0F;
        end
        if (f == 2 && i == 2) loop1 = 1'b0;
        step();
        wr_en1 = 1'b0;
      end
    end
    chk("loop busy_after", 32'(busy1), 0);

    // Start during SHIFT is ignored
    start1 = 1'b1; sel1 = 3'd7; msb1 = 1'b0;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_bit(1, "ign", i, 1'b1, i == 7);
      if (i == 2) begin
        start1 = 1'b1; sel1 = 3'd0; msb1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      step();
    end
    start1 = 1'b0;
    chk("ign busy_after", 32'(busy1), 0);

    // Stop at bit_idx=3
    start1 = 1'b1; sel1 = 3'd7; msb1 = 1'b0;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_bit(1, "stop", i, 1'b1, 1'b0);
      if (i == 3) stop1 = 1'b1;
      step();
    end
    stop1 = 1'b0;
    chk("stop valid", 32'(valid1), 0);
    chk("stop busy", 32'(busy1), 0);
    chk("stop done", 32'(done1), 0);
    step();
    chk("stop done_later", 32'(done1), 0);

    // Same-cycle write and start to one address: old data captured
    wr_en1 = 1'b1; wr_addr1 = 3'd4; wr_data1 = 8'h00;
    run_frame(1, 4'd4, 1'b0, 8'h1F, 8, "wrstart");
    run_frame(1, 4'd4, 1'b0, 8'h00, 8, "wrafter");

    // Reset mid-frame restores the table
    wr_en1 = 1'b1; wr_addr1 = 3'd0; wr_data1 = 8'h3C;
    step();
    wr_en1 = 1'b0;
    start1 = 1'b1; sel1 = 3'd0; msb1 = 1'b0;
    step();
    start1 = 1'b0;
    pat = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      check_bit(1, "prerst", i, pat[i], 1'b0);
      step();
    end
    reset = 1'b1;
    step();
    chk("midrst o", 32'(o1), 0);
    chk("midrst valid", 32'(valid1), 0);
    chk("midrst busy", 32'(busy1), 0);
    chk("midrst done", 32'(done1), 0);
    chk("midrst bit_idx", 32'(bit_idx1), 0);
    reset = 1'b0;
    step();
    run_frame(1, 4'd0, 1'b0, 8'h01, 8, "postrst");

    // WIDTH=4, DEPTH=16 instance
    run_frame(2, 4'd9, 1'b0, 8'h0F, 4, "w4_s9");
    run_frame(2, 4'd1, 1'b1, 8'h0C, 4, "w4_s1_msb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
